// File: rtl/gauss_frame_ctrl.sv
// gauss_frame_ctrl: frame sequencer for the 5x5 Gaussian line-buffer datapath.
// Accepts the pixel stream, drives shift enable, line-buffer address and
// zero-pad select, flushes the window after the last pixel, and tags each
// output beat (valid/SOF/EOL/last/border) in step with the datapath pipeline.
module gauss_frame_ctrl #(
  parameter int unsigned IMG_W    = 1024,
  parameter int unsigned IMG_H    = 1024,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  input  logic                     m_ready,
  output logic                     m_valid,
  output logic                     m_user,
  output logic                     m_eol,
  output logic                     m_last,
  output logic                     m_border,
  output logic                     pipe_en,
  output logic                     pad_sel,
  output logic [$clog2(IMG_W)-1:0] lb_addr,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned P  = 2 * IMG_W + 2;
  localparam int unsigned T  = N + P + PIPE_LAT;
  localparam int unsigned AW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(T);

  localparam logic [CW-1:0] N_LAST   = CW'(N - 1);
  localparam logic [CW-1:0] P_C      = CW'(P);
  localparam logic [CW-1:0] NP_C     = CW'(N + P);
  localparam logic [CW-1:0] T_LAST   = CW'(T - 1);
  localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  typedef struct packed {
    logic valid;
    logic user;
    logic eol;
    logic last;
    logic border;
  } tag_t;

  state_t          state;
  logic [CW-1:0]   adv_cnt;
  logic [CW-1:0]   in_cnt;
  logic [RW-1:0]   c_row;
  logic [AW-1:0]   c_col;
  logic            live;
  logic            adv_ok;
  tag_t            new_tag;
  tag_t            pipe_q [PIPE_LAT];

  assign adv_ok  = !m_valid || m_ready;
  assign pad_sel = (state == FLUSH);

  assign m_valid  = pipe_q[PIPE_LAT-1].valid;
  assign m_user   = pipe_q[PIPE_LAT-1].user;
  assign m_eol    = pipe_q[PIPE_LAT-1].eol;
  assign m_last   = pipe_q[PIPE_LAT-1].last;
  assign m_border = pipe_q[PIPE_LAT-1].border;

  // Handshake and advance enable; live keeps the input closed while in reset.
  always_comb begin
    s_ready = 1'b0;
    pipe_en = 1'b0;
    if (live) begin
      if (state == RUN) begin
        s_ready = adv_ok;
        pipe_en = s_valid && adv_ok;
      end else begin
        pipe_en = adv_ok;
      end
    end
  end

  // Tag for the window center produced by the current advance.
  always_comb begin
    new_tag = '0;
    if (adv_cnt >= P_C && adv_cnt < NP_C) begin
      new_tag.valid  = 1'b1;
      new_tag.user   = (c_row == '0) && (c_col == '0);
      new_tag.eol    = (c_col == COL_LAST);
      new_tag.last   = (c_row == ROW_LAST) && (c_col == COL_LAST);
      new_tag.border = (c_row < RW'(2)) || (c_row >= RW'(IMG_H - 2)) ||
                       (c_col < AW'(2)) || (c_col >= AW'(IMG_W - 2));
    end
  end

  // Frame FSM, counters, line-buffer address and tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      adv_cnt    <= '0;
      in_cnt     <= '0;
      c_row      <= '0;
      c_col      <= '0;
      lb_addr    <= '0;
      live       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
    end else begin
      live       <= 1'b1;
      frame_done <= m_valid && m_ready && m_last;

      if (pipe_en) begin
        pipe_q[0] <= new_tag;
        for (int unsigned i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];

        if (state == FLUSH && adv_cnt == T_LAST) begin
          state   <= RUN;
          adv_cnt <= '0;
          in_cnt  <= '0;
          c_row   <= '0;
          c_col   <= '0;
          lb_addr <= '0;
        end else begin
          adv_cnt <= adv_cnt + 1'b1;
          lb_addr <= (lb_addr == COL_LAST) ? '0 : lb_addr + 1'b1;
          if (new_tag.valid) begin
            if (c_col == COL_LAST) begin
              c_col <= '0;
              c_row <= (c_row == ROW_LAST) ? '0 : c_row + 1'b1;
            end else begin
              c_col <= c_col + 1'b1;
            end
          end
        end
      end

      // Either the count reaching N or an s_last ends the input phase;
      // they must coincide, otherwise the frame is flagged.
      if (state == RUN && s_valid && s_ready) begin
        in_cnt <= in_cnt + 1'b1;
        if (in_cnt == N_LAST || s_last) begin
          state <= FLUSH;
          if ((in_cnt == N_LAST) != s_last) frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/gauss_frame_ctrl.md
# gauss_frame_ctrl

Frame sequencer for the 5x5 Gaussian line-buffer datapath. It accepts the input pixel stream and drives the datapath's shift enable, line-buffer addressing and zero-pad select. It flushes the window after the last pixel, so the datapath emits exactly one output per input pixel. Output beats are tagged with valid/SOF/EOL/last/border in lock-step with the datapath pipeline, and back-pressure comes from the downstream threshold stage.

## Interface
Parameters:
- IMG_W, 1024: pixels per line (>=5)
- IMG_H, 1024: lines per frame (>=5)
- PIPE_LAT, 2: datapath advances between window load and gray_out register (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input pixel valid
- s_last  in  1  input marks last pixel of frame
- s_ready  out  1  input accepted when s_valid && s_ready
- m_ready  in  1  downstream ready
- m_valid  out  1  output beat valid (tag aligned with datapath gray_out)
- m_user  out  1  first pixel of frame (SOF)
- m_eol  out  1  last pixel of a line
- m_last  out  1  last pixel of frame
- m_border  out  1  center pixel within 2 of any edge; datapath forces output to 0
- pipe_en  out  1  datapath/line-buffer shift enable and line-buffer write enable
- pad_sel  out  1  datapath feeds 0 instead of s_data
- lb_addr  out  $clog2(IMG_W)  line-buffer read/write address
- frame_done  out  1  one-cycle pulse when frame's last output beat is accepted
- frame_err  out  1  sticky; cleared only by reset

## Operation
- N = IMG_W*IMG_H; P = 2*IMG_W+2 (window centering delay); total advances per frame T = N+P+PIPE_LAT.
- adv_ok = !m_valid || m_ready (combinational).
- States:
  - RUN: s_ready = adv_ok; pipe_en = s_valid && adv_ok; pad_sel = 0.
  - FLUSH: s_ready = 0; pipe_en = adv_ok; pad_sel = 1.
- adv_cnt counts pipe_en cycles from 0; in_cnt counts accepted inputs.
- RUN -> FLUSH:
  - Accepted beat with in_cnt == N-1. If s_last is 0 at that beat, set frame_err.
  - Accepted beat with s_last and in_cnt < N-1 (early last). Set frame_err; the remaining positions are zero-padded.
- FLUSH -> RUN: on the advance with adv_cnt == T-1. All counters clear. The next frame starts at the following cycle.
- lb_addr increments on every pipe_en and wraps IMG_W-1 -> 0. It clears at frame boundary.
- Tag generation on each pipe_en, with c = adv_cnt - P the center index:
  - tag.valid = P <= adv_cnt < N+P
  - user = (c == 0), eol = (c mod IMG_W == IMG_W-1), last = (c == N-1)
  - border = row<2 || row>=IMG_H-2 || col<2 || col>=IMG_W-2
  - Tags enter a PIPE_LAT-deep shift register advanced only by pipe_en. The head of the register drives m_*.
  - Track center row/col with wrap counters, not division.
- m_* remain stable while m_valid && !m_ready.
- frame_done pulses when the beat with m_last is accepted (m_valid && m_ready && m_last).

## Timing
- Reset values: s_ready 0 during reset; after release, s_ready = 1 in RUN with an empty pipe. Also after release: m_valid/m_user/m_eol/m_last/m_border 0, pipe_en 0, pad_sel 0, lb_addr 0, frame_done 0, frame_err 0. State RUN, all counters 0.
- s_ready and pipe_en are combinational in m_ready (and s_valid for pipe_en). There is no skid buffer.
- Latency: input pixel k is accepted on advance k. The output centered on pixel c appears at the head after advance c+P+PIPE_LAT-1, registered, i.e. visible the cycle after that advance.
- Simultaneous m_ready low and s_valid high: no acceptance, no shift; state frozen.
- Extra s_valid after the frame completes belongs to the next frame. There is no drop.
- Async reset mid-frame: the pipe empties immediately. The partial frame is discarded and no frame_done occurs.
- Counter widths cover T-1 without overflow.

## Test plan
IMG_W=8, IMG_H=6, PIPE_LAT=2, so N=48, P=18, T=68.
- Continuous stream: 48 beats with s_last on #47 and m_ready=1. First m_valid with m_user=1 occurs 19 advances after the first accept. Exactly 48 m_valid beats are produced. FLUSH lasts 20 cycles with pad_sel=1. frame_done fires once. frame_err stays 0.
- Border tags: over the same frame, m_border=1 on exactly 48-8=40 beats; only rows 2-3, cols 2-5 are 0. m_eol is on every 8th beat.
- Back-pressure: toggle m_ready 1/0 each cycle. m_* stay stable while stalled. pipe_en is never asserted while m_valid && !m_ready. Output count is still 48.
- Early last: s_last on beat #29. frame_err=1, and 48 outputs are still emitted. The next frame starts with in_cnt=0 and m_user on its first output.
- Missing last: 48 beats with s_last=0. frame_err=1 and FLUSH is entered after beat #47. The 49th s_valid is held (s_ready=0) until FLUSH ends.
- Reset mid-frame: assert rst_n low after 20 accepts. All outputs go to their reset values within the same cycle. A following clean frame passes the first scenario.
